// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Round-robin Wishbone arbiter. Several bus masters share one Wishbone slave
// port. Ownership is granted for a whole cyc tenure: the owner keeps the bus
// until it drops its cyc. The next owner is the first requester found by
// searching upward from a rotating priority pointer. A watchdog ends stalled
// strobes with a one-cycle error pulse, so a slave that never acks cannot
// hang the bus.
//
// Parameters
//   NUM_MASTERS     number of requesting masters (2..8)
//   ADDR_WIDTH      Wishbone address width
//   DATA_WIDTH      Wishbone data width
//   TIMEOUT_CYCLES  stalled strobe cycles tolerated before an error (1..65535)
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      synchronous reset, active low
//   m_cyc_i    per-master cycle valid / bus request
//   m_stb_i    per-master strobe
//   m_we_i     per-master write enable
//   m_adr_i    packed master addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   m_dat_i    packed master write data, master k at [k*DATA_WIDTH +: DATA_WIDTH]
//   m_ack_o    per-master acknowledge (only the owner's bit can be set)
//   m_err_o    per-master watchdog error, one-cycle pulse
//   m_dat_o    slave read data, broadcast to every master
//   s_cyc_o    slave-side cycle
//   s_stb_o    slave-side strobe
//   s_we_o     slave-side write enable
//   s_adr_o    slave-side address
//   s_dat_o    slave-side write data
//   s_ack_i    slave acknowledge
//   s_dat_i    slave read data
//   gnt_o      registered one-hot grant, zero while idle
//   busy_o     high while a master owns the bus
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,

    input  logic [NUM_MASTERS-1:0]           m_cyc_i,
    input  logic [NUM_MASTERS-1:0]           m_stb_i,
    input  logic [NUM_MASTERS-1:0]           m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]           m_ack_o,
    output logic [NUM_MASTERS-1:0]           m_err_o,
    output logic [DATA_WIDTH-1:0]            m_dat_o,

    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [ADDR_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    input  logic                             s_ack_i,
    input  logic [DATA_WIDTH-1:0]            s_dat_i,

    output logic [NUM_MASTERS-1:0]           gnt_o,
    output logic                             busy_o
);

    // -------------------------------------------------------------------------
    // Local parameters and types
    // -------------------------------------------------------------------------
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_MASTERS - 1);
    localparam logic [15:0]            WD_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       g_q,     g_d;      // index of the current owner
    logic [IDX_W-1:0]       ptr_q,   ptr_d;    // highest-priority master next time
    logic [NUM_MASTERS-1:0] gnt_q,   gnt_d;
    logic [15:0]            wd_q,    wd_d;     // consecutive stalled strobe cycles

    // -------------------------------------------------------------------------
    // Shared decode
    // -------------------------------------------------------------------------
    // A stall is a strobe from the owner that the slave has not acked yet.
    // Both the watchdog update and the error output look at the same condition,
    // so it is decoded once here from the owner's raw inputs.
    logic owner_cyc;
    logic owner_stb;
    logic stalled;
    logic wd_hit;

    assign owner_cyc = m_cyc_i[g_q];
    assign owner_stb = m_stb_i[g_q];
    assign stalled   = (state_q == ST_BUSY) && owner_stb && !s_ack_i;
    assign wd_hit    = (wd_q == WD_LIMIT);

    // -------------------------------------------------------------------------
    // Round-robin search: first set bit of req at or above ptr, wrapping to 0.
    // Only called when at least one request is set, so the fallback value is
    // never used to grant an idle master.
    // -------------------------------------------------------------------------
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [IDX_W-1:0]       ptr
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!found && req[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    // The reset is sampled on the clock edge, so an active cycle is aborted at
    // the edge where rst_i is seen low.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            wd_q    <= wd_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable driven here gets a hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        wd_d    = wd_q;

        unique case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (|m_cyc_i) begin
                    g_d     = rr_pick(m_cyc_i, ptr_q);
                    gnt_d   = ONE_HOT0 << g_d;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (!owner_cyc) begin
                    // End of tenure: the master just served drops to lowest
                    // priority by moving the pointer past it.
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    wd_d    = '0;
                    ptr_d   = (g_q == LAST_IDX) ? '0 : g_q + IDX_W'(1);
                end else if (stalled) begin
                    // On the timeout cycle the error fires and the count
                    // restarts, so a master that keeps strobing gets a fresh
                    // timeout window. An ack in that cycle is not a stall,
                    // which is how an ack wins over a coinciding timeout.
                    wd_d = wd_hit ? '0 : wd_q + 16'd1;
                end else begin
                    wd_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                wd_d    = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    // The slave-side signals and the ack path are pure muxes on the registered
    // owner index, so transfers inside a tenure run at the slave's own rate.
    always_comb begin
        busy_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;

        if (state_q == ST_BUSY) begin
            busy_o       = 1'b1;
            s_cyc_o      = owner_cyc;
            s_stb_o      = owner_stb;
            s_we_o       = m_we_i[g_q];
            s_adr_o      = m_adr_i[g_q*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_o      = m_dat_i[g_q*DATA_WIDTH +: DATA_WIDTH];
            m_ack_o[g_q] = s_ack_i;
            m_err_o[g_q] = stalled && wd_hit;
        end
    end

    // Read data is broadcast; only the owner sees an ack, so others ignore it.
    assign m_dat_o = s_dat_i;
    assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int TO = 8;

    logic              clk;
    logic              rst;
    logic [N-1:0]      cyc, stb, we;
    logic [AW-1:0]     adr [N];
    logic [DW-1:0]     dat [N];
    logic [N*AW-1:0]   m_adr;
    logic [N*DW-1:0]   m_dat;
    logic [N-1:0]      m_ack_o, m_err_o;
    logic [DW-1:0]     m_dat_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic              s_ack;
    logic [DW-1:0]     s_dat;
    logic [N-1:0]      gnt_o;
    logic              busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the bus (-1 = nobody), who is first in line,
    // and how long the current run of unanswered strobes has been.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_stall = 0;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            m_adr[k*AW +: AW] = adr[k];
            m_dat[k*DW +: DW] = dat[k];
        end
    end

    wb_rr_arbiter #(
        .NUM_MASTERS   (N),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .m_cyc_i(cyc),
        .m_stb_i(stb),
        .m_we_i (we),
        .m_adr_i(m_adr),
        .m_dat_i(m_dat),
        .m_ack_o(m_ack_o),
        .m_err_o(m_err_o),
        .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o),
        .s_we_o (s_we_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_ack_i(s_ack),
        .s_dat_i(s_dat),
        .gnt_o  (gnt_o),
        .busy_o (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Model update for one rising edge, from the inputs seen at that edge.
    task automatic model_edge();
        bit found;
        int k;
        if (!rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_stall = 0;
        end else if (m_owner < 0) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (!found && cyc[k]) begin
                    m_owner = k;
                    found   = 1;
                end
            end
            m_stall = 0;
        end else if (!cyc[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_stall = 0;
        end else if (stb[m_owner] && !s_ack) begin
            m_stall = (m_stall == TO) ? 0 : m_stall + 1;
        end else begin
            m_stall = 0;
        end
    endtask

    // Advance one clock: inputs are held across the rising edge, the model
    // follows that edge, and control returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst   = 1'b1;
        s_dat = 16'h1234;
        #1;
        n_checks++;
        if ({busy_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m_ack_o, m_err_o, gnt_o} !== '0)
            $display("FAIL reset_values: gnt=%b busy=%b scyc=%b sstb=%b swe=%b sadr=%h sdat=%h ack=%b err=%b, all required 0",
                     gnt_o, busy_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m_ack_o, m_err_o);
        else n_pass++;
        n_checks++;
        if (m_dat_o !== 16'h1234) $display("FAIL read_passthrough: got %h want 1234", m_dat_o);
        else n_pass++;
    endtask

    task automatic test_single_master();
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
        adr[2] = 32'h10; dat[2] = 16'hBEEF;
        #1;
        n_checks++;
        if (gnt_o !== 4'b0000) $display("FAIL single_gnt_early: got %b want 0000", gnt_o);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (gnt_o !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", gnt_o);
        else n_pass++;
        n_checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o} !== {3'b111, 32'h10, 16'hBEEF})
            $display("FAIL single_slave_side: got cyc/stb/we=%b%b%b adr=%h dat=%h want 111 00000010 beef",
                     s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o);
        else n_pass++;
        n_checks++;
        if (m_ack_o !== 4'b0000) $display("FAIL single_wait_ack: got %b want 0000", m_ack_o);
        else n_pass++;
        tick();
        tick();
        s_ack = 1'b1;
        #1;
        n_checks++;
        if (m_ack_o !== 4'b0100) $display("FAIL single_ack: got %b want 0100", m_ack_o);
        else n_pass++;
        tick();
        s_ack = 1'b0; stb[2] = 1'b0; we[2] = 1'b0; cyc[2] = 1'b0;
        #1;
        n_checks++;
        if (s_cyc_o !== 1'b0 || gnt_o !== 4'b0100)
            $display("FAIL single_release_pending: got scyc=%b gnt=%b want 0 0100", s_cyc_o, gnt_o);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (gnt_o !== 4'b0000 || busy_o !== 1'b0)
            $display("FAIL single_idle: got gnt=%b busy=%b want 0000 0", gnt_o, busy_o);
        else n_pass++;
        // Pointer now sits at 3: with 0 and 3 both asking, 3 wins.
        cyc[0] = 1'b1; cyc[3] = 1'b1;
        tick();
        #1;
        n_checks++;
        if (gnt_o !== 4'b1000) $display("FAIL single_ptr3: got %b want 1000", gnt_o);
        else n_pass++;
        cyc = '0;
        tick();
    endtask

    task automatic test_fairness();
        int k;
        rst = 1'b0;
        cyc = 4'hF;
        tick();
        rst = 1'b1;
        tick();
        for (int n = 0; n < 5; n++) begin
            k = n % N;
            #1;
            n_checks++;
            if (gnt_o !== 4'(1 << k)) $display("FAIL rr_order[%0d]: got %b want %b", n, gnt_o, 4'(1 << k));
            else n_pass++;
            stb[k] = 1'b1; s_ack = 1'b1;
            #1;
            n_checks++;
            if (m_ack_o !== 4'(1 << k)) $display("FAIL rr_ack[%0d]: got %b want %b", n, m_ack_o, 4'(1 << k));
            else n_pass++;
            tick();
            stb[k] = 1'b0; s_ack = 1'b0; cyc[k] = 1'b0;
            tick();
            #1;
            n_checks++;
            if (gnt_o !== 4'b0000) $display("FAIL rr_dead_cycle[%0d]: got %b want 0000", n, gnt_o);
            else n_pass++;
            if (n < 4) cyc[k] = 1'b1;
            else cyc = '0;
            tick();
        end
    endtask

    task automatic test_priority_rotation();
        cyc[3] = 1'b1;
        tick();
        #1;
        n_checks++;
        if (gnt_o !== 4'b1000) $display("FAIL prio_m3: got %b want 1000", gnt_o);
        else n_pass++;
        cyc[3] = 1'b0;
        tick();
        cyc[0] = 1'b1; cyc[1] = 1'b1;
        tick();
        #1;
        n_checks++;
        if (gnt_o !== 4'b0001) $display("FAIL prio_first_m0: got %b want 0001", gnt_o);
        else n_pass++;
        cyc[0] = 1'b0;
        tick();
        tick();
        #1;
        n_checks++;
        if (gnt_o !== 4'b0010) $display("FAIL prio_then_m1: got %b want 0010", gnt_o);
        else n_pass++;
        cyc[1] = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h20;
        tick();
        for (int c = 1; c <= TO + 1; c++) begin
            #1;
            n_checks++;
            if (m_err_o !== ((c == TO + 1) ? 4'b0010 : 4'b0000))
                $display("FAIL wd_err stall %0d: got %b want %b", c, m_err_o, (c == TO + 1) ? 4'b0010 : 4'b0000);
            else n_pass++;
            if (c == TO + 1) begin
                n_checks++;
                if (gnt_o !== 4'b0010 || m_ack_o !== 4'b0000)
                    $display("FAIL wd_grant_kept: got gnt=%b ack=%b want 0010 0000", gnt_o, m_ack_o);
                else n_pass++;
            end
            tick();
        end
        for (int c = 1; c <= TO; c++) begin
            #1;
            n_checks++;
            if (m_err_o !== 4'b0000 || gnt_o !== 4'b0010)
                $display("FAIL wd_rearm stall %0d: got err=%b gnt=%b want 0000 0010", c, m_err_o, gnt_o);
            else n_pass++;
            tick();
        end
        s_ack = 1'b1;
        #1;
        n_checks++;
        if (m_err_o !== 4'b0000 || m_ack_o !== 4'b0010)
            $display("FAIL wd_ack_wins: got err=%b ack=%b want 0000 0010", m_err_o, m_ack_o);
        else n_pass++;
        tick();
        s_ack = 1'b0;
        #1;
        n_checks++;
        if (m_err_o !== 4'b0000) $display("FAIL wd_after_ack: got %b want 0000", m_err_o);
        else n_pass++;
        stb[1] = 1'b0; cyc[1] = 1'b0;
        tick();
    endtask

    task automatic test_isolation();
        logic [N-1:0] want_ack;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'hA0; dat[0] = 16'h5555;
        tick();
        cyc[3] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            stb[3] = 1'($urandom_range(1));
            adr[3] = $urandom;
            s_ack  = 1'($urandom_range(1));
            want_ack = s_ack ? 4'b0001 : 4'b0000;
            #1;
            n_checks++;
            if (m_ack_o !== want_ack || s_adr_o !== 32'hA0)
                $display("FAIL isolation[%0d]: got ack=%b adr=%h want %b 000000a0", c, m_ack_o, s_adr_o, want_ack);
            else n_pass++;
            tick();
        end
        stb = '0; s_ack = 1'b0; cyc[0] = 1'b0;
        tick();
        tick();
        #1;
        n_checks++;
        if (gnt_o !== 4'b1000) $display("FAIL isolation_m3_kept: got %b want 1000", gnt_o);
        else n_pass++;
        cyc[3] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_cycle();
        cyc[1] = 1'b1;
        tick();
        cyc[1] = 1'b0;
        tick();
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 32'h30;
        tick();
        #1;
        n_checks++;
        if (gnt_o !== 4'b0100) $display("FAIL midrst_grant: got %b want 0100", gnt_o);
        else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        cyc[0] = 1'b1;
        #1;
        n_checks++;
        if ({busy_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m_ack_o, m_err_o, gnt_o} !== '0)
            $display("FAIL midrst_values: gnt=%b busy=%b scyc=%b sstb=%b adr=%h ack=%b err=%b, all required 0",
                     gnt_o, busy_o, s_cyc_o, s_stb_o, s_adr_o, m_ack_o, m_err_o);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (gnt_o !== 4'b0001) $display("FAIL midrst_m0_first: got %b want 0001", gnt_o);
        else n_pass++;
        cyc = '0; stb = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0]  e_gnt, e_ack, e_err;
        logic          e_busy, e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        bit            stall_phase;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            stall_phase = (c >= 1000);
            for (int k = 0; k < N; k++) begin
                if (!cyc[k]) cyc[k] = ($urandom_range(3) == 0);
                else if (stall_phase ? ($urandom_range(63) == 0) : ($urandom_range(7) == 0)) cyc[k] = 1'b0;
                stb[k] = stall_phase ? ($urandom_range(7) != 0) : 1'($urandom_range(1));
                we[k]  = 1'($urandom_range(1));
                adr[k] = $urandom;
                dat[k] = 16'($urandom);
            end
            s_ack = stall_phase ? ($urandom_range(15) == 0) : ($urandom_range(2) == 0);
            s_dat = 16'($urandom);
            rst   = ($urandom_range(299) != 0);

            e_gnt = '0; e_ack = '0; e_err = '0;
            e_busy = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
            e_adr = '0; e_dat = '0;
            if (m_owner >= 0) begin
                e_busy = 1'b1;
                e_gnt[m_owner] = 1'b1;
                e_cyc = cyc[m_owner];
                e_stb = stb[m_owner];
                e_we  = we[m_owner];
                e_adr = adr[m_owner];
                e_dat = dat[m_owner];
                e_ack[m_owner] = s_ack;
                e_err[m_owner] = stb[m_owner] && !s_ack && (m_stall == TO);
            end
            #1;
            n_checks++;
            if ({gnt_o, busy_o} !== {e_gnt, e_busy})
                $display("FAIL rand_grant @%0d: got gnt=%b busy=%b want %b %b", c, gnt_o, busy_o, e_gnt, e_busy);
            else n_pass++;
            n_checks++;
            if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o} !== {e_cyc, e_stb, e_we, e_adr, e_dat})
                $display("FAIL rand_slave @%0d: got %b%b%b %h %h want %b%b%b %h %h", c,
                         s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, e_cyc, e_stb, e_we, e_adr, e_dat);
            else n_pass++;
            n_checks++;
            if ({m_ack_o, m_err_o} !== {e_ack, e_err})
                $display("FAIL rand_ack_err @%0d: got ack=%b err=%b want %b %b", c, m_ack_o, m_err_o, e_ack, e_err);
            else n_pass++;
            n_checks++;
            if (m_dat_o !== s_dat) $display("FAIL rand_rdata @%0d: got %h want %h", c, m_dat_o, s_dat);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        cyc = '0; stb = '0; we = '0;
        for (int k = 0; k < N; k++) begin
            adr[k] = '0;
            dat[k] = '0;
        end
        s_ack = 1'b0;
        s_dat = '0;
        @(negedge clk);

        test_reset();
        test_single_master();
        test_fairness();
        test_priority_rotation();
        test_watchdog();
        test_isolation();
        test_reset_mid_cycle();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
